// File: rtl/answer_arbiter.sv
// answer_arbiter -- quiz-show buzzer arbiter.
// Every raw key is synchronized (2 flops) and debounced; a debounced rising
// edge produces a one-cycle press event.  The host arms a round with
// key_start; the first player to buzz locks the round.  While locked, the
// host adjusts that player's score (0..99, saturating) with key_add/key_sub.
// An armed round with no buzz returns to idle after TIMEOUT clocks.
//
// Ports:
//   clk         single clock, all state changes on posedge
//   rst_n       asynchronous active-low reset
//   key_player  raw player buzzers (active-high, asynchronous)
//   key_start   raw host start / re-arm key
//   key_add     raw host score +1 key
//   key_sub     raw host score -1 key
//   player      index of current or last winner
//   score       score of the player shown on 'player' (0..99)
//   armed       high while ARMED
//   locked      high while LOCKED
//   timeout_p   one-cycle pulse when an ARMED round expires
module answer_arbiter #(
   parameter int DB_CYCLES = 20,
   parameter int TIMEOUT   = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_player,
   input  logic       key_start,
   input  logic       key_add,
   input  logic       key_sub,
   output logic [1:0] player,
   output logic [7:0] score,
   output logic       armed,
   output logic       locked,
   output logic       timeout_p
);

   localparam int NK  = 7;
   localparam int DBW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
   localparam int TOW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [7:0] SCORE_MAX = 8'd99;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKED} state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] s);
      return (s >= SCORE_MAX) ? SCORE_MAX : s + 8'd1;
   endfunction

   function automatic logic [7:0] sat_dec(input logic [7:0] s);
      return (s == 8'd0) ? 8'd0 : s - 8'd1;
   endfunction

   // Lowest index wins when several buzzers fire in the same cycle.
   function automatic logic [1:0] lowest_idx(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Key bit order: [3:0] players, [4] start, [5] add, [6] sub.
   logic [NK-1:0] raw;
   assign raw = {key_sub, key_add, key_start, key_player};

   logic [NK-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NK-1:0] db_q, db_d, ev_q, ev_d;
   logic [DBW-1:0] db_cnt_q [NK];
   logic [DBW-1:0] db_cnt_d [NK];

   state_t     state_q, state_d;
   logic [TOW-1:0] to_cnt_q, to_cnt_d;
   logic [1:0] player_q, player_d;
   logic [7:0] score_q [4];
   logic [7:0] score_d [4];
   logic       timeout_p_q, timeout_p_d;

   // Debounce: the counter tracks how many consecutive synchronized samples
   // have disagreed with the debounced level; any agreeing sample restarts it.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      db_d    = db_q;
      for (int k = 0; k < NK; k++) begin
         db_cnt_d[k] = '0;
         if (sync2_q[k] != db_q[k]) begin
            if (db_cnt_q[k] == DBW'(DB_CYCLES - 1)) db_d[k] = sync2_q[k];
            else                                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
         end
      end
      ev_d = db_d & ~db_q;
   end

   logic [3:0] pl_ev;
   logic       start_ev, add_ev, sub_ev;
   assign pl_ev    = ev_q[3:0];
   assign start_ev = ev_q[4];
   assign add_ev   = ev_q[5];
   assign sub_ev   = ev_q[6];

   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      player_d    = player_q;
      score_d     = score_q;
      timeout_p_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d  = S_ARMED;
               to_cnt_d = '0;
            end
         end
         S_ARMED: begin
            // A buzz takes priority over both re-arm and expiry.
            if (|pl_ev) begin
               state_d  = S_LOCKED;
               player_d = lowest_idx(pl_ev);
               to_cnt_d = '0;
            end else if (start_ev) begin
               to_cnt_d = '0;
            end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
               state_d     = S_IDLE;
               timeout_p_d = 1'b1;
               to_cnt_d    = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_LOCKED: begin
            if (start_ev) begin
               state_d  = S_ARMED;
               to_cnt_d = '0;
            end
            if (add_ev && !sub_ev)      score_d[player_q] = sat_inc(score_q[player_q]);
            else if (sub_ev && !add_ev) score_d[player_q] = sat_dec(score_q[player_q]);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         ev_q        <= '0;
         for (int k = 0; k < NK; k++) db_cnt_q[k] <= '0;
         state_q     <= S_IDLE;
         to_cnt_q    <= '0;
         player_q    <= 2'd0;
         for (int p = 0; p < 4; p++) score_q[p] <= 8'd0;
         timeout_p_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         db_q        <= db_d;
         ev_q        <= ev_d;
         db_cnt_q    <= db_cnt_d;
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         player_q    <= player_d;
         score_q     <= score_d;
         timeout_p_q <= timeout_p_d;
      end
   end

   assign player    = player_q;
   assign score     = score_q[player_q];
   assign armed     = (state_q == S_ARMED);
   assign locked    = (state_q == S_LOCKED);
   assign timeout_p = timeout_p_q;

endmodule

// File: doc/answer_arbiter.md
ANSWER_ARBITER -- requirements
Module: answer_arbiter

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 20; consecutive stable synchronized samples required before a key is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 1000; clocks in ARMED with no press before returning to IDLE.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port key_player  input  4  raw player buzzers, active-high, asynchronous to clk.
REQ-006 SHALL have port key_start  input  1  raw host start/re-arm key, active-high.
REQ-007 SHALL have port key_add  input  1  raw host score +1 key, active-high.
REQ-008 SHALL have port key_sub  input  1  raw host score -1 key, active-high.
REQ-009 SHALL have port player  output  2  index of current or last winner; feeds the display player input.
REQ-010 SHALL have port score  output  8  binary score 0..99 of the player on the player output; feeds the display score input.
REQ-011 SHALL have port armed  output  1  high while in ARMED.
REQ-012 SHALL have port locked  output  1  high while in LOCKED.
REQ-013 SHALL have port timeout_p  output  1  one-cycle pulse when ARMED expires.

Function
REQ-014 SHALL pass every raw key through a 2-flop synchronizer, then a per-key debouncer.
REQ-015 Debounced level SHALL change only after DB_CYCLES consecutive equal synchronized samples that differ from it.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge.
- No event on release.
- Held key yields exactly one event.
REQ-017 SHALL implement states IDLE, ARMED, LOCKED.
REQ-018 IDLE: start event -> ARMED; player, add and sub events ignored.
REQ-019 ARMED: any player event -> LOCKED in the next cycle.
- player <= index of the pressing key.
- Simultaneous events: lowest index wins.
REQ-020 ARMED: timeout counter increments every cycle.
- Reaching TIMEOUT-1 with no player event: -> IDLE and timeout_p=1 for one cycle.
- player and score unchanged.
REQ-021 ARMED: start event SHALL reset the timeout counter to 0 and remain in ARMED.
REQ-022 Player event and timeout in the same cycle: the player event wins, no timeout_p.
REQ-023 LOCKED: further player events ignored; start event -> ARMED with counter 0; player retains last winner.
REQ-024 LOCKED: add event increments the winner's score, saturating at 99.
REQ-025 LOCKED: sub event decrements the winner's score, saturating at 0.
REQ-026 Add and sub in the same cycle SHALL leave the score unchanged.
REQ-027 Add/sub in IDLE or ARMED SHALL be ignored.
REQ-028 SHALL keep four independent 8-bit score registers.
- score output = register selected by the player output, combinationally.
- Never exceeds 99.
REQ-029 armed and locked SHALL be registered state decodes, never both high.

Reset
REQ-030 rst_n low SHALL immediately force:
- state IDLE;
- player=0, all score registers=0;
- armed=0, locked=0, timeout_p=0;
- synchronizers, debounced levels and counters cleared to 0.
REQ-031 Reset mid-operation (ARMED or LOCKED) SHALL discard the round and scores.
- First accepted event after release requires a full debounce of a fresh 0->1 edge.
- A key held through reset release SHALL produce one event after DB_CYCLES+2 cycles.

Verification (DB_CYCLES=4, TIMEOUT=50)
REQ-032 Reset, key_start high 10 cycles -> armed=1, locked=0, player=0, score=0.
REQ-033 Armed, key_player=4'b0100 held -> locked=1, player=2, score=0; later key_player=4'b0001 -> player stays 2.
REQ-034 Armed, key_player=4'b1010 applied same cycle -> player=1; add pressed 3 times -> score=3; sub 5 times -> score=0.
REQ-035 Armed, no press for 50 cycles -> timeout_p high exactly 1 cycle, armed=0, locked=0, player/score unchanged.
REQ-036 Key bouncing 1-0-1 at 2-cycle intervals then stable high -> exactly one event, after stable high held 4+2 cycles.
REQ-037 Player 3 locked with score 99, add pressed -> score stays 99; rst_n pulsed low in LOCKED -> all outputs 0 immediately.
